// File: rtl/db_qp_ram_pp_pkg.sv
// db_qp_ram_pp_pkg: shared defaults and bank-state encoding for the deblocking QP ping-pong buffer
package db_qp_ram_pp_pkg;
    localparam int DB_QP_DATA_W = 20;
    localparam int DB_QP_ADDR_W = 6;
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } bank_st_e;
endpackage

// File: rtl/db_qp_ram_sp_param.sv
// db_qp_ram_sp_param: single-port RAM, low-active cen/wen, 1-cycle read latency
// Ports: clk; adr_i address; cen_i chip enable (low); wen_i write enable (low);
//        wr_dat_i write data; rd_dat_o read data one cycle after a read access.
module db_qp_ram_sp_param
    import db_qp_ram_pp_pkg::*;
#(
    parameter int DATA_W = DB_QP_DATA_W,
    parameter int ADDR_W = DB_QP_ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic              cen_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    output logic [DATA_W-1:0] rd_dat_o
);
`ifdef XM_MODEL
    db_qp_ram_sp_macro #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_macro (
        .clk      (clk),
        .adr_i    (adr_i),
        .cen_i    (cen_i),
        .wen_i    (wen_i),
        .wr_dat_i (wr_dat_i),
        .rd_dat_o (rd_dat_o)
    );
`else
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_dat_q;
    always_ff @(posedge clk) begin
        if (!cen_i && !wen_i) mem[adr_i] <= wr_dat_i;
        if (!cen_i && wen_i) rd_dat_q <= mem[adr_i];
    end
    assign rd_dat_o = rd_dat_q;
`endif
endmodule

// File: rtl/db_qp_ram_pp.sv
// db_qp_ram_pp: multi-bank QP buffer; writer fills one bank while reader drains a completed one
// Ports: clk, rst (async, high);
//        write side wr_en_i/wr_adr_i/wr_dat_i/wr_done_i, wr_rdy_o;
//        read side rd_en_i/rd_adr_i/rd_done_i, rd_rdy_o, rd_dat_o/rd_val_o;
//        full_cnt_o banks currently FULL; err_o sticky protocol violation.
module db_qp_ram_pp
    import db_qp_ram_pp_pkg::*;
#(
    parameter int DATA_W   = DB_QP_DATA_W,
    parameter int ADDR_W   = DB_QP_ADDR_W,
    parameter int BANK_NUM = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_adr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              wr_done_i,
    output logic              wr_rdy_o,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    input  logic              rd_done_i,
    output logic              rd_rdy_o,
    output logic [DATA_W-1:0] rd_dat_o,
    output logic              rd_val_o,
    output logic [2:0]        full_cnt_o,
    output logic              err_o
);
    localparam int SEL_W = $clog2(BANK_NUM);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(BANK_NUM - 1);

    bank_st_e          state_q [BANK_NUM];
    bank_st_e          state_d [BANK_NUM];
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, rd_bank_q, rd_bank_d;
    logic              rd_val_q, rd_val_d, err_q, err_d;
    logic [2:0]        full_cnt_q, full_cnt_d;
    logic              wr_rdy, rd_rdy, wr_ok, rd_ok, wr_close, rd_close;
    logic [BANK_NUM-1:0] cen, wen;
    logic [DATA_W-1:0] ram_rd [BANK_NUM];

    always_comb begin
        wr_rdy     = state_q[wr_sel_q] != ST_FULL;
        rd_rdy     = state_q[rd_sel_q] == ST_FULL;
        wr_ok      = wr_en_i && wr_rdy;
        rd_ok      = rd_en_i && rd_rdy;
        // a write in the closing cycle lands first, so done on an EMPTY bank is legal then
        wr_close   = wr_done_i && (state_q[wr_sel_q] == ST_FILLING || wr_ok);
        rd_close   = rd_done_i && rd_rdy;
        full_cnt_d = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            state_d[b] = state_q[b];
            if (wr_ok && wr_sel_q == SEL_W'(b)) state_d[b] = ST_FILLING;
            if (wr_close && wr_sel_q == SEL_W'(b)) state_d[b] = ST_FULL;
            if (rd_close && rd_sel_q == SEL_W'(b)) state_d[b] = ST_EMPTY;
            // read and write banks differ whenever both are legal, so no double booking
            cen[b]     = !((wr_ok && wr_sel_q == SEL_W'(b)) || (rd_ok && rd_sel_q == SEL_W'(b)));
            wen[b]     = !(wr_ok && wr_sel_q == SEL_W'(b));
            full_cnt_d = full_cnt_d + 3'(state_d[b] == ST_FULL);
        end
        wr_sel_d  = wr_close ? (wr_sel_q == SEL_LAST ? '0 : wr_sel_q + 1'b1) : wr_sel_q;
        rd_sel_d  = rd_close ? (rd_sel_q == SEL_LAST ? '0 : rd_sel_q + 1'b1) : rd_sel_q;
        rd_bank_d = rd_ok ? rd_sel_q : rd_bank_q;
        rd_val_d  = rd_ok;
        err_d     = err_q || (wr_en_i && !wr_rdy) || (rd_en_i && !rd_rdy)
                    || (rd_done_i && !rd_rdy) || (wr_done_i && !wr_close);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) state_q[b] <= ST_EMPTY;
            wr_sel_q   <= '0;
            rd_sel_q   <= '0;
            rd_bank_q  <= '0;
            rd_val_q   <= 1'b0;
            err_q      <= 1'b0;
            full_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_bank_q  <= rd_bank_d;
            rd_val_q   <= rd_val_d;
            err_q      <= err_d;
            full_cnt_q <= full_cnt_d;
        end
    end

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        db_qp_ram_sp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
            .clk      (clk),
            .adr_i    (wen[g] ? rd_adr_i : wr_adr_i),
            .cen_i    (cen[g]),
            .wen_i    (wen[g]),
            .wr_dat_i (wr_dat_i),
            .rd_dat_o (ram_rd[g])
        );
    end

    assign wr_rdy_o   = wr_rdy;
    assign rd_rdy_o   = rd_rdy;
    assign rd_val_o   = rd_val_q;
    assign rd_dat_o   = rd_val_q ? ram_rd[rd_bank_q] : '0;
    assign full_cnt_o = full_cnt_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_db_qp_ram_pp.sv
// tb_db_qp_ram_pp: directed self-checking bench for db_qp_ram_pp (BANK_NUM=2 and BANK_NUM=3)
module tb_db_qp_ram_pp;
    import db_qp_ram_pp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 0, wr_done = 0, rd_en = 0, rd_done = 0;
    logic [5:0]  wr_adr = 0, rd_adr = 0;
    logic [19:0] wr_dat = 0, rd_dat;
    logic        wr_rdy, rd_rdy, rd_val, err;
    logic [2:0]  full_cnt;

    logic        t_wr_en = 0, t_wr_done = 0, t_rd_en = 0, t_rd_done = 0;
    logic [5:0]  t_wr_adr = 0, t_rd_adr = 0;
    logic [19:0] t_wr_dat = 0, t_rd_dat;
    logic        t_wr_rdy, t_rd_rdy, t_rd_val, t_err;
    logic [2:0]  t_full_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    db_qp_ram_pp #(.DATA_W(20), .ADDR_W(6), .BANK_NUM(2)) u_dut (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat), .wr_done_i(wr_done), .wr_rdy_o(wr_rdy),
        .rd_en_i(rd_en), .rd_adr_i(rd_adr), .rd_done_i(rd_done), .rd_rdy_o(rd_rdy),
        .rd_dat_o(rd_dat), .rd_val_o(rd_val), .full_cnt_o(full_cnt), .err_o(err)
    );

    db_qp_ram_pp #(.DATA_W(20), .ADDR_W(6), .BANK_NUM(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .wr_en_i(t_wr_en), .wr_adr_i(t_wr_adr), .wr_dat_i(t_wr_dat), .wr_done_i(t_wr_done), .wr_rdy_o(t_wr_rdy),
        .rd_en_i(t_rd_en), .rd_adr_i(t_rd_adr), .rd_done_i(t_rd_done), .rd_rdy_o(t_rd_rdy),
        .rd_dat_o(t_rd_dat), .rd_val_o(t_rd_val), .full_cnt_o(t_full_cnt), .err_o(t_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_wr_rdy", 32'(wr_rdy), 1);
        check("rst_rd_rdy", 32'(rd_rdy), 0);
        check("rst_rd_val", 32'(rd_val), 0);
        check("rst_rd_dat", 32'(rd_dat), 0);
        check("rst_full_cnt", 32'(full_cnt), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        tick;
        // basic ping-pong: fill bank0, close, read addr 5
        for (int i = 0; i < 64; i++) begin
            wr_en = 1; wr_adr = 6'(i); wr_dat = 20'(i + 'h100);
            tick;
        end
        wr_en = 0;
        check("fill_rd_rdy", 32'(rd_rdy), 0);
        wr_done = 1;
        tick;
        wr_done = 0;
        check("pp_rd_rdy", 32'(rd_rdy), 1);
        check("pp_full_cnt", 32'(full_cnt), 1);
        check("pp_wr_rdy", 32'(wr_rdy), 1);
        rd_en = 1; rd_adr = 5;
        tick;
        rd_en = 0;
        check("pp_rd_val", 32'(rd_val), 1);
        check("pp_rd_dat", 32'(rd_dat), 'h105);
        tick;
        check("idle_rd_val", 32'(rd_val), 0);
        check("idle_rd_dat", 32'(rd_dat), 0);
        // concurrent: read bank0 while writing bank1
        rd_en = 1; rd_adr = 10; wr_en = 1; wr_adr = 63; wr_dat = 'hABCDE;
        tick;
        check("cc_rd_dat0", 32'(rd_dat), 'h10A);
        rd_adr = 20; wr_adr = 0; wr_dat = 'h00777;
        tick;
        check("cc_rd_dat1", 32'(rd_dat), 'h114);
        rd_en = 0; wr_en = 0; wr_done = 1;
        tick;
        wr_done = 0;
        check("cc_full_cnt", 32'(full_cnt), 2);
        check("cc_wr_rdy", 32'(wr_rdy), 0);
        check("cc_wr_sel", 32'(u_dut.wr_sel_q), 0);
        // full stall: illegal write must not touch bank0 addr 0
        wr_en = 1; wr_adr = 0; wr_dat = 'h12345;
        tick;
        wr_en = 0;
        check("st_err", 32'(err), 1);
        check("st_full_cnt", 32'(full_cnt), 2);
        check("st_wr_rdy", 32'(wr_rdy), 0);
        rd_en = 1; rd_adr = 0; rd_done = 1;
        tick;
        rd_en = 0; rd_done = 0;
        check("st_rd_val", 32'(rd_val), 1);
        check("st_rd_dat", 32'(rd_dat), 'h100);
        check("st_wr_rdy_rel", 32'(wr_rdy), 1);
        check("st_full_cnt_rel", 32'(full_cnt), 1);
        check("st_rd_rdy_rel", 32'(rd_rdy), 1);
        check("st_bank0", 32'(u_dut.state_q[0]), 32'(ST_EMPTY));
        rd_en = 1; rd_adr = 63;
        tick;
        check("b1_rd_dat63", 32'(rd_dat), 'hABCDE);
        rd_adr = 0;
        tick;
        rd_en = 0;
        check("b1_rd_dat0", 32'(rd_dat), 'h777);
        // simultaneous done: close bank0 while releasing bank1
        wr_en = 1; wr_adr = 3; wr_dat = 'h33333;
        tick;
        wr_en = 0; wr_done = 1; rd_done = 1;
        tick;
        wr_done = 0; rd_done = 0;
        check("sd_bank0", 32'(u_dut.state_q[0]), 32'(ST_FULL));
        check("sd_bank1", 32'(u_dut.state_q[1]), 32'(ST_EMPTY));
        check("sd_full_cnt", 32'(full_cnt), 1);
        check("sd_rd_rdy", 32'(rd_rdy), 1);
        check("sd_wr_rdy", 32'(wr_rdy), 1);
        rd_en = 1; rd_adr = 3;
        tick;
        check("sd_rd_val", 32'(rd_val), 1);
        check("sd_rd_dat", 32'(rd_dat), 'h33333);
        // asynchronous reset in the middle of a read burst
        #3 rst = 1'b1;
        #1;
        check("ar_rd_val", 32'(rd_val), 0);
        check("ar_rd_dat", 32'(rd_dat), 0);
        check("ar_wr_rdy", 32'(wr_rdy), 1);
        check("ar_rd_rdy", 32'(rd_rdy), 0);
        check("ar_full_cnt", 32'(full_cnt), 0);
        check("ar_err", 32'(err), 0);
        rd_en = 0;
        #2 rst = 1'b0;
        tick;
        // BANK_NUM=3: fill three banks, drain them, refill bank0 after wrap
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 4; a++) begin
                t_wr_en = 1; t_wr_adr = 6'(a); t_wr_dat = 20'('h30000 + k * 16 + a);
                tick;
            end
            t_wr_en = 0; t_wr_done = 1;
            tick;
            t_wr_done = 0;
        end
        check("w3_full_cnt", 32'(t_full_cnt), 3);
        check("w3_wr_rdy", 32'(t_wr_rdy), 0);
        check("w3_rd_rdy", 32'(t_rd_rdy), 1);
        for (int k = 0; k < 3; k++) begin
            t_rd_en = 1; t_rd_adr = 2; t_rd_done = 1;
            tick;
            check($sformatf("w3_rd_bank%0d", k), 32'(t_rd_dat), 32'('h30000 + k * 16 + 2));
        end
        t_rd_en = 0; t_rd_done = 0;
        check("w3_empty_cnt", 32'(t_full_cnt), 0);
        check("w3_empty_rd_rdy", 32'(t_rd_rdy), 0);
        check("w3_empty_wr_rdy", 32'(t_wr_rdy), 1);
        check("w3_wr_sel_wrap", 32'(u_dut3.wr_sel_q), 0);
        for (int a = 0; a < 4; a++) begin
            t_wr_en = 1; t_wr_adr = 6'(a); t_wr_dat = 20'('h40000 + a);
            tick;
        end
        t_wr_en = 0; t_wr_done = 1;
        tick;
        t_wr_done = 0;
        check("w3_bank0_full", 32'(u_dut3.state_q[0]), 32'(ST_FULL));
        check("w3_refill_cnt", 32'(t_full_cnt), 1);
        check("w3_refill_rd_rdy", 32'(t_rd_rdy), 1);
        t_rd_en = 1; t_rd_adr = 1;
        tick;
        t_rd_en = 0;
        check("w3_refill_dat", 32'(t_rd_dat), 'h40001);
        check("w3_err_clean", 32'(t_err), 0);
        t_wr_done = 1;
        tick;
        t_wr_done = 0;
        check("w3_done_empty_err", 32'(t_err), 1);
        check("w3_done_empty_cnt", 32'(t_full_cnt), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
